// File: rtl/video_scaler_2x.sv
// Streaming 2x nearest-neighbour upscaler for the 30-bit RGB Avalon-ST path.
// Each input pixel is emitted twice, and each completed line is replayed once from a line buffer.
module video_scaler_2x #(
  parameter int DW       = 29,
  parameter int EW       = 1,
  parameter int WIDTH_IN = 320,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW:0]   stream_in_data,
  input  logic          stream_in_startofpacket,
  input  logic          stream_in_endofpacket,
  input  logic [EW:0]   stream_in_empty,
  input  logic          stream_in_valid,
  output logic          stream_in_ready,
  input  logic          stream_out_ready,
  output logic [DW:0]   stream_out_data,
  output logic          stream_out_startofpacket,
  output logic          stream_out_endofpacket,
  output logic [EW:0]   stream_out_empty,
  output logic          stream_out_valid
);

  typedef enum logic {FILL, REPEAT} state_t;

  localparam logic [CW:0]   LAST_COL = (CW+1)'(WIDTH_IN - 1);
  localparam logic [CW:0]   COL_ONE  = (CW+1)'(1);
  localparam logic [CW+1:0] LEN_ONE  = (CW+2)'(1);

  state_t        state, state_d;
  logic [CW:0]   col, col_d, col_inc, rd_addr;
  logic [CW+1:0] wr_len, wr_len_d, col_len;
  logic          phase, phase_d;
  logic          line_eop, line_eop_d;
  logic          primed, primed_d;
  logic          adv, last_rep, we;

  logic [DW:0]   linebuf [WIDTH_IN];
  logic [DW:0]   rd_data;

  logic [DW:0]   data_d;
  logic          valid_d, sop_d, eop_d;

  // Input empty carries no information for full-pixel beats.
  logic unused_empty;
  assign unused_empty = ^stream_in_empty;

  assign adv      = stream_out_ready | ~stream_out_valid;
  assign col_inc  = col + COL_ONE;
  assign col_len  = (CW+2)'(col) + LEN_ONE;
  assign last_rep = (col_len == wr_len);

  assign stream_out_empty = '0;

  // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state;
    col_d           = col;
    phase_d         = phase;
    line_eop_d      = line_eop;
    wr_len_d        = wr_len;
    primed_d        = primed;
    data_d          = stream_out_data;
    valid_d         = stream_out_valid;
    sop_d           = stream_out_startofpacket;
    eop_d           = stream_out_endofpacket;
    stream_in_ready = 1'b0;
    we              = 1'b0;
    rd_addr         = col;

    unique case (state)
      FILL: begin
        primed_d = 1'b0;
        if (adv) begin
          data_d  = stream_in_data;
          valid_d = stream_in_valid;
          eop_d   = 1'b0;
          if (!phase) begin
            // First copy: peek at the held input without consuming it.
            sop_d = stream_in_startofpacket;
            if (stream_in_valid) begin
              phase_d = 1'b1;
              if (stream_in_startofpacket) col_d = '0;
            end
          end else begin
            sop_d           = 1'b0;
            stream_in_ready = 1'b1;
            if (stream_in_valid) begin
              we      = 1'b1;
              phase_d = 1'b0;
              if (col == LAST_COL || stream_in_endofpacket) begin
                wr_len_d   = col_len;
                line_eop_d = stream_in_endofpacket;
                col_d      = '0;
                state_d    = REPEAT;
              end else begin
                col_d = col_inc;
              end
            end
          end
        end
      end

      REPEAT: begin
        // The first REPEAT cycle only fetches column 0; afterwards the read runs one beat ahead.
        primed_d = 1'b1;
        if (primed && adv && phase) rd_addr = last_rep ? '0 : col_inc;
        if (adv) begin
          sop_d = 1'b0;
          if (!primed) begin
            valid_d = 1'b0;
            eop_d   = 1'b0;
          end else begin
            data_d  = rd_data;
            valid_d = 1'b1;
            eop_d   = phase & line_eop & last_rep;
            phase_d = ~phase;
            if (phase) begin
              if (last_rep) begin
                col_d      = '0;
                line_eop_d = 1'b0;
                state_d    = FILL;
              end else begin
                col_d = col_inc;
              end
            end
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= FILL;
      col                      <= '0;
      phase                    <= 1'b0;
      line_eop                 <= 1'b0;
      wr_len                   <= '0;
      primed                   <= 1'b0;
      stream_out_data          <= '0;
      stream_out_valid         <= 1'b0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
    end else begin
      state                    <= state_d;
      col                      <= col_d;
      phase                    <= phase_d;
      line_eop                 <= line_eop_d;
      wr_len                   <= wr_len_d;
      primed                   <= primed_d;
      stream_out_data          <= data_d;
      stream_out_valid         <= valid_d;
      stream_out_startofpacket <= sop_d;
      stream_out_endofpacket   <= eop_d;
    end
  end

  // NOTE: the line buffer is not reset; it maps onto block RAM and is always written before it is read.
  always_ff @(posedge clk) begin
    if (we) linebuf[col] <= stream_in_data;
    rd_data <= linebuf[rd_addr];
  end

endmodule

// File: tb/tb_video_scaler_2x.sv
// Directed bench for video_scaler_2x with WIDTH_IN=4: a scoreboard of hand-listed beats,
// a hold checker for backpressure, and an idle-cycle counter for the line-replay transition.
module tb_video_scaler_2x;

  localparam int DW = 29;
  localparam int EW = 1;

  typedef struct packed {
    logic [DW:0] data;
    logic        sop;
    logic        eop;
    logic [EW:0] empty;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW:0]   stream_in_data = '0;
  logic          stream_in_startofpacket = 1'b0;
  logic          stream_in_endofpacket = 1'b0;
  logic [EW:0]   stream_in_empty = '0;
  logic          stream_in_valid = 1'b0;
  logic          stream_in_ready;
  logic          stream_out_ready = 1'b1;
  logic [DW:0]   stream_out_data;
  logic          stream_out_startofpacket;
  logic          stream_out_endofpacket;
  logic [EW:0]   stream_out_empty;
  logic          stream_out_valid;

  int    n_checks = 0;
  int    n_err    = 0;
  beat_t obs[$];
  beat_t exp_q[$];

  logic  toggle_en = 1'b0;
  logic  held_pending = 1'b0;
  beat_t held;
  logic  cnt_en = 1'b0, cnt_started = 1'b0, cnt_done = 1'b0;
  int    idle_cycles = 0, valid_beats = 0;

  localparam logic [DW:0] PA = 30'h3ff00001;
  localparam logic [DW:0] PB = 30'h000ffc02;
  localparam logic [DW:0] PC = 30'h000003ff;
  localparam logic [DW:0] PD = 30'h15555555;
  localparam logic [DW:0] PX = 30'h2aaaaaa0;
  localparam logic [DW:0] PY = 30'h0123abcd;
  localparam logic [DW:0] PZ = 30'h3c0f00f1;
  localparam logic [DW:0] PP = 30'h1badcafe;

  // Hand-listed beat order for the 4x2 frame of pixels 1..8.
  int frame_beats [32] = '{1,1,2,2,3,3,4,4, 1,1,2,2,3,3,4,4,
                           5,5,6,6,7,7,8,8, 5,5,6,6,7,7,8,8};

  video_scaler_2x #(.DW(DW), .EW(EW), .WIDTH_IN(4), .CW(1)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .stream_in_data           (stream_in_data),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_ready          (stream_in_ready),
    .stream_out_ready         (stream_out_ready),
    .stream_out_data          (stream_out_data),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Downstream ready: held high, or toggled every cycle when toggle_en is set.
  always begin
    @(posedge clk);
    #1;
    stream_out_ready = toggle_en ? ~stream_out_ready : 1'b1;
  end

  // Output monitor, sampled on the falling edge where everything is stable.
  always @(negedge clk) begin
    if (!reset_n) begin
      held_pending = 1'b0;
    end else begin
      if (held_pending) begin
        check("hold_data",  {2'b0, stream_out_data}, {2'b0, held.data});
        check("hold_valid", {31'b0, stream_out_valid}, 32'd1);
        check("hold_sop",   {31'b0, stream_out_startofpacket}, {31'b0, held.sop});
        check("hold_eop",   {31'b0, stream_out_endofpacket}, {31'b0, held.eop});
      end
      if (stream_out_valid && !stream_out_ready)
        check("in_ready_under_bp", {31'b0, stream_in_ready}, 32'd0);
      held_pending = stream_out_valid && !stream_out_ready;
      held = '{stream_out_data, stream_out_startofpacket, stream_out_endofpacket, stream_out_empty};
      if (stream_out_valid && stream_out_ready)
        obs.push_back('{stream_out_data, stream_out_startofpacket, stream_out_endofpacket, stream_out_empty});
      if (cnt_en && !cnt_done) begin
        if (stream_out_valid) begin
          cnt_started = 1'b1;
          valid_beats++;
          if (stream_out_endofpacket) cnt_done = 1'b1;
        end else if (cnt_started) begin
          idle_cycles++;
        end
      end
    end
  end

  task automatic push_exp(input logic [DW:0] d, input logic s, input logic e);
    exp_q.push_back('{d, s, e, 2'b00});
  endtask

  // Present one pixel at posedge+1 and hold it until the DUT takes it.
  task automatic send_pixel(input logic [DW:0] d, input logic s, input logic e);
    int n = 0;
    stream_in_data          = d;
    stream_in_startofpacket = s;
    stream_in_endofpacket   = e;
    stream_in_valid         = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!stream_in_ready && n < 200);
    check("in_accept", {31'b0, stream_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    stream_in_valid         = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket   = 1'b0;
  endtask

  task automatic send_frame_1to8();
    for (int i = 1; i <= 8; i++)
      send_pixel(30'(i), i == 1, i == 8);
  endtask

  task automatic expect_frame_1to8();
    for (int i = 0; i < 32; i++)
      push_exp(30'(frame_beats[i]), i == 0, i == 31);
  endtask

  task automatic compare_run(input string name);
    int n = 0;
    while (obs.size() < exp_q.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (16) @(negedge clk);
    check({name, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), {2'b0, obs[i].data}, {2'b0, exp_q[i].data});
      check($sformatf("%s_sop%0d", name, i), {31'b0, obs[i].sop}, {31'b0, exp_q[i].sop});
      check($sformatf("%s_eop%0d", name, i), {31'b0, obs[i].eop}, {31'b0, exp_q[i].eop});
      check($sformatf("%s_empty%0d", name, i), {30'b0, obs[i].empty}, 32'd0);
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, stream_out_valid}, 32'd0);
    check("rst_sop",   {31'b0, stream_out_startofpacket}, 32'd0);
    check("rst_eop",   {31'b0, stream_out_endofpacket}, 32'd0);
    check("rst_data",  {2'b0, stream_out_data}, 32'd0);
    check("rst_empty", {30'b0, stream_out_empty}, 32'd0);
    check("rst_in_ready", {31'b0, stream_in_ready}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full 4x2 frame with continuous ready; also measure idle cycles and beat count.
    cnt_en = 1'b1;
    expect_frame_1to8();
    send_frame_1to8();
    compare_run("frame");
    cnt_en = 1'b0;
    check("idle_cycles", idle_cycles, 32'd2);
    check("valid_beats", valid_beats, 32'd32);

    // Same frame with downstream ready toggling every cycle.
    toggle_en = 1'b1;
    expect_frame_1to8();
    send_frame_1to8();
    compare_run("frame_bp");
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Short line ended by eop on the third pixel, then a one-pixel frame.
    push_exp(PA, 1, 0); push_exp(PA, 0, 0); push_exp(PB, 0, 0); push_exp(PB, 0, 0);
    push_exp(PC, 0, 0); push_exp(PC, 0, 0);
    push_exp(PA, 0, 0); push_exp(PA, 0, 0); push_exp(PB, 0, 0); push_exp(PB, 0, 0);
    push_exp(PC, 0, 0); push_exp(PC, 0, 1);
    push_exp(PD, 1, 0); push_exp(PD, 0, 0); push_exp(PD, 0, 0); push_exp(PD, 0, 1);
    send_pixel(PA, 1, 0);
    send_pixel(PB, 0, 0);
    send_pixel(PC, 0, 1);
    send_pixel(PD, 1, 1);
    compare_run("short");

    // New sop at column 2 discards the partial line without replay.
    push_exp(PX, 1, 0); push_exp(PX, 0, 0); push_exp(PY, 0, 0); push_exp(PY, 0, 0);
    push_exp(PZ, 1, 0); push_exp(PZ, 0, 0); push_exp(PZ, 0, 0); push_exp(PZ, 0, 1);
    send_pixel(PX, 1, 0);
    send_pixel(PY, 0, 0);
    send_pixel(PZ, 1, 1);
    compare_run("resync");

    // Asynchronous reset in the middle of a replay.
    send_pixel(PA, 1, 0);
    send_pixel(PB, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, stream_out_valid}, 32'd0);
    check("async_rst_eop",   {31'b0, stream_out_endofpacket}, 32'd0);
    obs.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(PP, 1, 0); push_exp(PP, 0, 0);
    send_pixel(PP, 1, 0);
    compare_run("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
